// File: rtl/edge_pkg.sv
// Shared definitions for the multi-channel edge detector.
// Mode encodings, legal parameter ranges and a range clamp.
package edge_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_POS  = 2'b01,
    MODE_NEG  = 2'b10,
    MODE_BOTH = 2'b11
  } mode_e;

  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 32;
  localparam int SYNC_MIN  = 2;
  localparam int SYNC_MAX  = 4;
  localparam int FILT_MIN  = 1;
  localparam int FILT_MAX  = 15;

  // filter counter width, enough for FILT_MAX-1
  localparam int FCW = 4;

  function automatic int clamp(int v, int lo, int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/edge_chan.sv
// One channel: synchroniser, glitch filter, edge pulses.
// Level only moves after FILT_LEN agreeing synced cycles.
module edge_chan
  import edge_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic cin,
  output logic level,
  output logic p,
  output logic n
);

  localparam logic [FCW-1:0] FMAX = FCW'(FILT_LEN - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [FCW-1:0]         cnt;
  logic                   synced;
  logic                   diff;
  logic                   accept;
  logic                   p_q;
  logic                   n_q;

  assign synced = sync[SYNC_STAGES-1];
  assign diff   = synced != level;
  assign accept = diff && (cnt == FMAX);

  // metastability chain, oldest sample at the top bit
  always_ff @(posedge clk) begin
    if (rst) sync <= '0;
    else     sync <= {sync[SYNC_STAGES-2:0], cin};
  end

  // filter: count differing cycles, accept on the last one
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
      p_q   <= 1'b0;
      n_q   <= 1'b0;
    end else if (!en) begin
      cnt   <= '0;
      level <= synced;
      p_q   <= 1'b0;
      n_q   <= 1'b0;
    end else begin
      p_q <= accept & synced;
      n_q <= accept & ~synced;
      if (!diff || accept) cnt <= '0;
      else                 cnt <= cnt + 1'b1;
      if (accept) level <= synced;
    end
  end

  assign p = p_q & en;
  assign n = n_q & en;

endmodule

// File: rtl/edge_detect_multi.sv
// Multi-channel filtered edge detector with sticky flags,
// interrupt and a saturating event counter.
module edge_detect_multi
  import edge_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] cin,
  input  logic [WIDTH-1:0] clr,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] e,
  output logic [WIDTH-1:0] flag,
  output logic             irq,
  output logic [CNT_W-1:0] ecnt
);

  localparam int SYNC_N = clamp(SYNC_STAGES, SYNC_MIN, SYNC_MAX);
  localparam int FILT_N = clamp(FILT_LEN, FILT_MIN, FILT_MAX);

  logic pos_en;
  logic neg_en;

  assign pos_en = (mode == MODE_POS) || (mode == MODE_BOTH);
  assign neg_en = (mode == MODE_NEG) || (mode == MODE_BOTH);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    edge_chan #(
      .SYNC_STAGES(SYNC_N),
      .FILT_LEN   (FILT_N)
    ) u_chan (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .cin  (cin[i]),
      .level(level[i]),
      .p    (p[i]),
      .n    (n[i])
    );
  end

  assign e   = (p & {WIDTH{pos_en}}) | (n & {WIDTH{neg_en}});
  assign irq = |flag;

  // sticky flags (set wins over clear) and saturating count
  always_ff @(posedge clk) begin
    if (rst) begin
      flag <= '0;
      ecnt <= '0;
    end else begin
      flag <= (flag & ~clr) | e;
      if (|e && (ecnt != '1)) ecnt <= ecnt + 1'b1;
    end
  end

endmodule

// File: doc/edge_detect_multi.md
EDGE_DETECT_MULTI -- requirements
Module: edge_detect_multi

Interface
REQ-001 Parameter WIDTH, default 4: number of independent input channels (1..32).
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser flops per channel (2..4).
REQ-003 Parameter FILT_LEN, default 3: consecutive synchronised cycles a new level must hold before acceptance (1..15; 1 = no filtering).
REQ-004 Parameter CNT_W, default 8: event counter width.
REQ-005 Clk  in  1  sole clock; all state changes on rising edge.
REQ-006 Rst  in  1  reset, synchronous, active-high.
REQ-007 En  in  1  detection enable.
REQ-008 Mode  in  2  event select: 00 off, 01 rising, 10 falling, 11 both.
REQ-009 Cin  in  WIDTH  asynchronous channel inputs.
REQ-010 Clr  in  WIDTH  per-channel write-1-to-clear for Flag.
REQ-011 Level  out  WIDTH  filtered, synchronised level per channel.
REQ-012 P  out  WIDTH  one-cycle rising-edge pulse per channel.
REQ-013 N  out  WIDTH  one-cycle falling-edge pulse per channel.
REQ-014 E  out  WIDTH  Mode-selected event pulse per channel.
REQ-015 Flag  out  WIDTH  sticky per-channel event flag.
REQ-016 Irq  out  1  OR-reduction of Flag.
REQ-017 Ecnt  out  CNT_W  saturating count of cycles with any E bit high.

Function
REQ-018 Each Cin bit SHALL pass through SYNC_STAGES flops before any other logic.
REQ-019 Per-channel filter: synced value != Level increments a counter; counter reaching FILT_LEN-1 with value still differing updates Level and zeroes counter; synced == Level zeroes counter.
REQ-020 Pulses shorter than FILT_LEN synchronised cycles SHALL NOT change Level or produce P/N.
REQ-021 P[i] high exactly one cycle when Level[i] goes 0->1; N[i] likewise for 1->0; P and N never both high on one channel.
REQ-022 Latency: a steady Cin change first sampled at edge 1 SHALL make P/N high in the cycle after edge SYNC_STAGES+FILT_LEN.
REQ-023 E = (P & Mode[0]) | (N & Mode[1]), combinational; Mode changes take effect in the same cycle.
REQ-024 Flag[i] set on E[i]; cleared by Clr[i]; E[i] and Clr[i] in the same cycle -> Flag[i] stays set.
REQ-025 Ecnt increments by 1 in any cycle with E != 0, regardless of how many bits are set; holds at all-ones (no wrap).
REQ-026 En=0: P, N, E forced 0; filter counters held at 0; Level follows synced input directly; Flag and Ecnt hold. Re-enabling SHALL NOT generate a spurious event.

Reset
REQ-027 Rst SHALL clear all synchroniser flops, filter counters, Level, P, N, E, Flag, Irq and Ecnt to 0, overriding all other inputs, including mid-filter.
REQ-028 After reset release with Cin high, a rising event SHALL be produced after the REQ-022 latency (if En=1).

Structure
REQ-029 Shared package edge_pkg SHALL hold Mode encodings (MODE_OFF, MODE_POS, MODE_NEG, MODE_BOTH) and parameter range limits.
REQ-030 Sub-module edge_chan (synchroniser, filter, P/N detect, one channel) SHALL be generated WIDTH times; Flag, Irq and Ecnt live in the top.

Verification
REQ-031 Defaults, En=1, Mode=01, Cin[0] 0->1 held -> P[0] single pulse in cycle after edge 5, E[0]=1, Flag[0]=1, Irq=1, Ecnt=1.
REQ-032 Cin[1] high for 2 synced cycles then low -> no P[1], no N[1], Level[1] stays 0.
REQ-033 Mode=10, Cin[2] 1->0 after settling -> N[2] pulse, E[2]=1; repeat with Mode=01 -> N[2] pulses, E[2]=0, Flag[2] unchanged.
REQ-034 Clr[3]=1 in same cycle as E[3]=1 -> Flag[3]=1; Clr[3] next cycle -> Flag[3]=0, Irq=0 if no other flags.
REQ-035 CNT_W=2, 5 separate events -> Ecnt reads 1,2,3,3,3.
REQ-036 Rst asserted mid-filter (counter=2) with Cin=1 -> all outputs 0 next cycle; after release P pulses after 5 edges; En toggled 0->1 with Cin steady -> no event.
